fft_sdf_stage: RTL
==================

Name: fft_sdf_stage

Overview:
- Parametrised multi-lane radix-2 delay-feedback FFT stage; successor to the fixed 16-lane, fixed-depth stage blocks.
- Each frame is 2*DELAY_BLKS input blocks of LANES samples:
  - First half (phase A) is buffered in an internal delay memory.
  - Second half (phase B) is butterflied against the buffered half.
- The diff path is multiplied by an externally supplied twiddle, with runtime FFT/IFFT conjugation, rounding, saturation and sticky overflow.
- Instances are chained to build the full pipeline.

Parameters:
- WIDTH, 10, input sample width per re/im component (signed).
- LANES, 16, samples processed per clock.
- DELAY_BLKS, 8, blocks in half a frame; delay memory holds DELAY_BLKS*LANES complex samples.
- TW_WIDTH, 10, twiddle component width (signed).
- TW_FRAC, 8, twiddle fractional bits; 1.0 = 2**TW_FRAC.
- OUT_W, WIDTH+2, output component width.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  input block valid
- in_sop  in  1  first block of a frame; qualified by in_valid
- inv  in  1  1 = IFFT: twiddle conjugated; sampled at in_sop
- din_re/din_im  in  LANES x WIDTH  input block
- tw_rd  out  1  twiddle ROM read strobe
- tw_addr  out  clog2(DELAY_BLKS)  twiddle block index
- tw_re/tw_im  in  LANES x TW_WIDTH  twiddle data from a registered ROM; valid the cycle after tw_rd
- ovf_clr  in  1  clears ovf
- out_valid  out  1  output block valid
- sum_re/sum_im  out  LANES x OUT_W  butterfly sum
- diff_re/diff_im  out  LANES x OUT_W  twiddled butterfly difference
- ovf  out  1  sticky saturation flag

Behaviour:
- Reset: all outputs 0, counters 0, phase = A, inv latch 0. Delay memory contents are not reset.
- Block counter blk (0..2*DELAY_BLKS-1):
  - Advances only on in_valid; gaps of any length are allowed.
  - Wraps from 2*DELAY_BLKS-1 to 0.
- in_sop && in_valid forces blk = 0 for that block, including mid-frame. The partial frame is dropped with no outputs for its remaining blocks.
- Phase A (blk < DELAY_BLKS): din is written to delay slot blk. No output.
- Phase B (blk >= DELAY_BLKS), with k = blk - DELAY_BLKS and a = delay slot k, b = din:
  - Cycle 0: tw_rd = 1, tw_addr = k (combinational from the counter).
  - Cycle 1: register s = a + b and d = a - b (WIDTH+1 bits, exact); tw arrives this cycle.
  - Cycle 2: register outputs and assert out_valid for 1 cycle.
  - Latency is 2 cycles from the accepting edge.
- Sum: s sign-extended to OUT_W.
- Diff, per lane:
  - inv = 0: re = dr*tr - di*ti, im = dr*ti + di*tr.
  - inv = 1: use ti := -ti before the products.
  - Full-precision product, then add 2**(TW_FRAC-1), then arithmetic shift right by TW_FRAC, then saturate to [-2**(OUT_W-1), 2**(OUT_W-1)-1].
- ovf: set on any lane/component saturating while out_valid. Cleared by ovf_clr; set has priority over clear in the same cycle.
- Memory read in phase B and write in phase A never target the same slot in the same cycle. The memory is read in the cycle of acceptance.
- inv changes apply only at the next in_sop.
- Asynchronous reset mid-operation: pipeline flushed, out_valid = 0 immediately, next frame requires in_sop or starts at blk = 0.
- Back-to-back frames: blk wrap with no idle cycle is legal and produces continuous phase-B output.

Test Plan (WIDTH=10, LANES=16, DELAY_BLKS=8, TW_WIDTH=10, TW_FRAC=8):
- Reset: rstn low mid-stream → all outputs 0, ovf 0, out_valid 0 within the same cycle. First valid block after release is treated as blk 0.
- Basic butterfly: in_sop with 8 blocks all 100+0j, then 8 blocks all 20+0j, tw = 256+0j → 8 out_valid pulses, each 2 cycles after the matching phase-B input. sum = 120+0j, diff = 80+0j in every lane. tw_addr sequence 0..7.
- Twiddle/mode: a = 100, b = 20, tw = 0+256j:
  - inv = 0 → diff = 0+80j.
  - Next frame with inv = 1 at in_sop → diff = 0-80j.
  - Toggling inv mid-frame has no effect.
- Rounding and saturation:
  - d = 1023-1024j, tw = 511+511j → diff_re = 4086 → saturates to 2047, ovf = 1; ovf stays 1 until ovf_clr.
  - d = 3+0j, tw = 128+0j → diff_re = 2 (1.5 rounds half-up).
- Gaps and resync:
  - Random in_valid gaps → outputs identical to the gapless case, sample for sample.
  - in_sop at blk 11 → blocks 11..15 of the old frame produce no output; the new frame completes normally.
- Back-to-back frames: 3 frames with no idle cycles → 24 out_valid pulses. Sums match a golden model per frame, with no cross-frame mixing.

Source files
------------

// File: rtl/fft_sdf_stage.sv
// Radix-2 delay-feedback FFT stage over LANES samples per clock. The first half-frame
// is buffered; the second half is butterflied against it and the difference is twiddled.
module fft_sdf_stage #(
   parameter int WIDTH      = 10,
   parameter int LANES      = 16,
   parameter int DELAY_BLKS = 8,
   parameter int TW_WIDTH   = 10,
   parameter int TW_FRAC    = 8,
   parameter int OUT_W      = WIDTH + 2,
   localparam int AW        = (DELAY_BLKS > 1) ? $clog2(DELAY_BLKS) : 1
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic                            in_valid,
   input  logic                            in_sop,
   input  logic                            inv,
   input  logic [LANES-1:0][WIDTH-1:0]     din_re,
   input  logic [LANES-1:0][WIDTH-1:0]     din_im,
   output logic                            tw_rd,
   output logic [AW-1:0]                   tw_addr,
   input  logic [LANES-1:0][TW_WIDTH-1:0]  tw_re,
   input  logic [LANES-1:0][TW_WIDTH-1:0]  tw_im,
   input  logic                            ovf_clr,
   output logic                            out_valid,
   output logic [LANES-1:0][OUT_W-1:0]     sum_re,
   output logic [LANES-1:0][OUT_W-1:0]     sum_im,
   output logic [LANES-1:0][OUT_W-1:0]     diff_re,
   output logic [LANES-1:0][OUT_W-1:0]     diff_im,
   output logic                            ovf
);

   localparam int CW = $clog2(2 * DELAY_BLKS);
   localparam int SW = WIDTH + 1;
   localparam int PW = SW + TW_WIDTH + 2;
   localparam logic signed [PW-1:0] SAT_MAX = PW'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;
   localparam logic signed [PW-1:0] RND     = PW'(2 ** (TW_FRAC - 1));

   logic [CW-1:0] blk_q, blk_d, cur_blk;
   logic          inv_q, inv_d, phase_b, accept_b;
   logic [AW-1:0] slot;

   logic [LANES-1:0][WIDTH-1:0] mem_re [DELAY_BLKS];
   logic [LANES-1:0][WIDTH-1:0] mem_im [DELAY_BLKS];
   logic [LANES-1:0][WIDTH-1:0] a_re, a_im;

   logic                        v1_q, inv1_q;
   logic [LANES-1:0][SW-1:0]    s_re_d, s_im_d, d_re_d, d_im_d;
   logic [LANES-1:0][SW-1:0]    s_re_q, s_im_q, d_re_q, d_im_q;

   logic [LANES-1:0][OUT_W-1:0] sum_re_d, sum_im_d, diff_re_d, diff_im_d;
   logic [LANES-1:0][OUT_W-1:0] sum_re_q, sum_im_q, diff_re_q, diff_im_q;
   logic                        sat_any, out_valid_q, ovf_q;

   function automatic logic [OUT_W-1:0] clip(input logic signed [PW-1:0] x, output logic hit);
      hit = 1'b1;
      if (x > SAT_MAX)      return OUT_W'(SAT_MAX);
      else if (x < SAT_MIN) return OUT_W'(SAT_MIN);
      hit = 1'b0;
      return OUT_W'(x);
   endfunction

   // A start-of-frame block is always slot 0, which also drops any partial frame.
   always_comb begin
      cur_blk  = (in_valid && in_sop) ? '0 : blk_q;
      phase_b  = (cur_blk >= CW'(DELAY_BLKS));
      accept_b = in_valid && phase_b;
      slot     = phase_b ? AW'(cur_blk - CW'(DELAY_BLKS)) : AW'(cur_blk);
      blk_d    = blk_q;
      if (in_valid)
         blk_d = (cur_blk == CW'(2 * DELAY_BLKS - 1)) ? '0 : cur_blk + CW'(1);
      inv_d    = (in_valid && in_sop) ? inv : inv_q;
   end

   assign tw_rd   = accept_b;
   assign tw_addr = accept_b ? slot : '0;

   // NOTE: the delay memory has no reset; phase A always writes a slot before phase B reads it.
   always_ff @(posedge clk) begin
      if (in_valid && !phase_b) begin
         mem_re[slot] <= din_re;
         mem_im[slot] <= din_im;
      end
   end

   assign a_re = mem_re[slot];
   assign a_im = mem_im[slot];

   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         s_re_d[l] = SW'($signed(a_re[l])) + SW'($signed(din_re[l]));
         s_im_d[l] = SW'($signed(a_im[l])) + SW'($signed(din_im[l]));
         d_re_d[l] = SW'($signed(a_re[l])) - SW'($signed(din_re[l]));
         d_im_d[l] = SW'($signed(a_im[l])) - SW'($signed(din_im[l]));
      end
   end

   // Twiddle from the registered ROM lines up with the stage-1 difference.
   always_comb begin
      logic signed [PW-1:0] dr, di, tr, ti, pr, pi;
      logic                 hit_r, hit_i;
      // NOTE: every always_comb output gets a default before any conditional update.
      sat_any = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         dr = PW'($signed(d_re_q[l]));
         di = PW'($signed(d_im_q[l]));
         tr = PW'($signed(tw_re[l]));
         ti = inv1_q ? -PW'($signed(tw_im[l])) : PW'($signed(tw_im[l]));
         pr = ((dr * tr) - (di * ti) + RND) >>> TW_FRAC;
         pi = ((dr * ti) + (di * tr) + RND) >>> TW_FRAC;
         sum_re_d[l]  = OUT_W'($signed(s_re_q[l]));
         sum_im_d[l]  = OUT_W'($signed(s_im_q[l]));
         diff_re_d[l] = clip(pr, hit_r);
         diff_im_d[l] = clip(pi, hit_i);
         sat_any      = sat_any | hit_r | hit_i;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         blk_q       <= '0;
         inv_q       <= 1'b0;
         v1_q        <= 1'b0;
         inv1_q      <= 1'b0;
         s_re_q      <= '0;
         s_im_q      <= '0;
         d_re_q      <= '0;
         d_im_q      <= '0;
         out_valid_q <= 1'b0;
         sum_re_q    <= '0;
         sum_im_q    <= '0;
         diff_re_q   <= '0;
         diff_im_q   <= '0;
         ovf_q       <= 1'b0;
      end else begin
         blk_q       <= blk_d;
         inv_q       <= inv_d;
         v1_q        <= accept_b;
         out_valid_q <= v1_q;
         if (accept_b) begin
            inv1_q <= inv_q;
            s_re_q <= s_re_d;
            s_im_q <= s_im_d;
            d_re_q <= d_re_d;
            d_im_q <= d_im_d;
         end
         if (v1_q) begin
            sum_re_q  <= sum_re_d;
            sum_im_q  <= sum_im_d;
            diff_re_q <= diff_re_d;
            diff_im_q <= diff_im_d;
         end
         if (v1_q && sat_any) ovf_q <= 1'b1;
         else if (ovf_clr)    ovf_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign sum_re    = sum_re_q;
   assign sum_im    = sum_im_q;
   assign diff_re   = diff_re_q;
   assign diff_im   = diff_im_q;
   assign ovf       = ovf_q;

endmodule
